fb_port_arbiter: RTL and testbench

Single-port frame-buffer arbiter for the VGA display path. It shares one synchronous-read frame-buffer RAM between three users: the VGA pixel fetch (read, hard real-time, highest priority), the SPI command writer (buffered through a small write FIFO), and a built-in full-screen clear engine. It sits inside `top`, between the VGA timing/pixel pipeline, the SPI command decoder and the frame-buffer RAM, in the 25.175 MHz `clk` domain.

---
 rtl/fb_port_arbiter_if.sv | 28 ++
 rtl/fb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer RAM port bundle.
// The arbiter drives the master side; the synchronous-read RAM is the slave.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA fetch, buffered SPI writes
// and a full-screen clear engine share one synchronous-read RAM.
module fb_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FB_PIXELS  = 19200,
    parameter int FIFO_DEPTH = 4,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear_req,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [CNT_W-1:0]  fifo_count,
    fb_port_arbiter_if.master mem
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FB_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [DATA_W-1:0] clr_color_q;
    logic              done_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_hold_q;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic gnt_clr, gnt_fifo, clr_last, push, clr_start;

    assign wr_ready   = count_q < CNT_W'(FIFO_DEPTH);
    assign push       = wr_valid && wr_ready;
    assign clr_last   = gnt_clr && (clr_cnt_q == LAST_PIX);
    assign clr_start  = (state_q == IDLE) && clear_req;
    assign fifo_count = count_q;
    assign clear_busy = (state_q == CLEAR);
    assign clear_done = done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? mem.mem_rdata : rd_hold_q;

    // Fixed priority: the pixel fetch can never be stalled.
    always_comb begin
        gnt_clr       = 1'b0;
        gnt_fifo      = 1'b0;
        mem.mem_en    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        priority case (1'b1)
            rd_req: begin
                mem.mem_en   = 1'b1;
                mem.mem_addr = rd_addr;
            end
            (state_q == CLEAR): begin
                gnt_clr       = 1'b1;
                mem.mem_en    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = clr_cnt_q;
                mem.mem_wdata = clr_color_q;
            end
            (count_q != '0): begin
                gnt_fifo      = 1'b1;
                mem.mem_en    = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = fifo_addr[rd_ptr_q];
                mem.mem_wdata = fifo_data[rd_ptr_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (clear_req) state_d = CLEAR;
            CLEAR: if (clr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            done_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_hold_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= clr_last;
            rd_valid_q <= rd_req;
            if (rd_valid_q) rd_hold_q <= mem.mem_rdata;
            if (clr_start) begin
                clr_cnt_q   <= '0;
                clr_color_q <= clear_color;
            end else if (gnt_clr) begin
                clr_cnt_q <= clr_last ? '0 : clr_cnt_q + ADDR_W'(1);
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (gnt_fifo) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, gnt_fifo})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr_q] <= wr_addr;
            fifo_data[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized bench for fb_port_arbiter against a queue-based
// cycle model of the grant rules plus a golden frame-buffer image.
module tb_fb_port_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;
    localparam int FB     = 19200;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int MEMSZ  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_ready;
    logic              clear_req = 1'b0;
    logic [DATA_W-1:0] clear_color = '0;
    logic              clear_busy;
    logic              clear_done;
    logic [CNT_W-1:0]  fifo_count;

    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .FB_PIXELS(FB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .fifo_count(fifo_count), .mem(bus)
    );

    logic [DATA_W-1:0] ram  [MEMSZ];
    logic [DATA_W-1:0] gold [MEMSZ];
    logic [DATA_W-1:0] ram_q = '0;
    assign bus.mem_rdata = ram_q;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else ram_q <= ram[bus.mem_addr];
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t               q[$];
    bit                m_busy, m_done, m_rv;
    int                m_ptr;
    logic [DATA_W-1:0] m_color, m_rd;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0;
        m_done = 0;
        m_rv   = 0;
        m_ptr  = 0;
        m_rd   = '0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step();
        int g;
        logic              e_en, e_we;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d;
        bit                do_push, nd;
        wr_t               w;
        #1;
        g = rd_req ? 1 : m_busy ? 2 : (q.size() > 0) ? 3 : 0;
        e_en = (g != 0);
        e_we = (g >= 2);
        e_a  = '0;
        e_d  = '0;
        if (g == 1) e_a = rd_addr;
        if (g == 2) begin e_a = ADDR_W'(m_ptr); e_d = m_color; end
        if (g == 3) begin e_a = q[0].a; e_d = q[0].d; end
        chk("mem_en", bus.mem_en, e_en);
        chk("mem_we", bus.mem_we, e_we);
        chk("mem_addr", bus.mem_addr, e_a);
        chk("mem_wdata", bus.mem_wdata, e_d);
        chk("rd_valid", rd_valid, m_rv);
        chk("rd_data", rd_data, m_rd);
        chk("wr_ready", wr_ready, q.size() < DEPTH);
        chk("fifo_count", fifo_count, q.size());
        chk("clear_busy", clear_busy, m_busy);
        chk("clear_done", clear_done, m_done);
        @(posedge clk);
        do_push = wr_valid && (q.size() < DEPTH);
        if (g == 3) begin
            gold[q[0].a] = q[0].d;
            void'(q.pop_front());
        end
        if (do_push) begin
            w.a = wr_addr;
            w.d = wr_data;
            q.push_back(w);
        end
        nd = 0;
        if (g == 2) begin
            gold[m_ptr] = m_color;
            if (m_ptr == FB - 1) begin
                m_busy = 0;
                m_ptr  = 0;
                nd     = 1;
            end else m_ptr++;
        end else if (!m_busy && clear_req) begin
            m_busy  = 1;
            m_ptr   = 0;
            m_color = clear_color;
        end
        m_done = nd;
        m_rv   = rd_req;
        if (rd_req) m_rd = gold[rd_addr];
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rd_req    = 1'b0;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_clear(input logic [DATA_W-1:0] col,
                             input bit traffic);
        int cyc;
        clear_req   = 1'b1;
        clear_color = col;
        step();
        clear_req = 1'b0;
        cyc = 0;
        while (m_busy && cyc < 2 * FB) begin
            rd_req   = traffic && (cyc % 4 == 0);
            rd_addr  = ADDR_W'($urandom_range(0, MEMSZ - 1));
            wr_valid = traffic && (cyc == 50 || cyc == 51);
            wr_addr  = ADDR_W'($urandom_range(0, FB - 1));
            wr_data  = DATA_W'($urandom);
            step();
            cyc++;
        end
        chk("clear_timeout", m_busy, 0);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int a, n;
        for (int i = 0; i < MEMSZ; i++) begin
            ram[i]  = DATA_W'(i);
            gold[i] = DATA_W'(i);
        end
        do_reset();
        repeat (10) step();

        for (int i = 0; i < 8; i++) begin
            rd_req  = 1'b1;
            rd_addr = ADDR_W'(i);
            step();
        end
        rd_req = 1'b0;
        repeat (2) step();

        rd_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_addr  = ADDR_W'($urandom_range(0, MEMSZ - 1));
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'($urandom_range(0, FB - 1));
            wr_data  = DATA_W'($urandom);
            step();
        end
        wr_valid = 1'b0;
        step();
        rd_req = 1'b0;
        repeat (6) step();

        run_clear(12'hF00, 1'b0);
        run_clear(DATA_W'($urandom), 1'b1);

        clear_req   = 1'b1;
        clear_color = 12'h0A5;
        step();
        clear_req = 1'b0;
        n = 0;
        while (m_ptr != 100 && n < 300) begin
            wr_valid = (n < 2);
            wr_addr  = ADDR_W'($urandom_range(0, FB - 1));
            wr_data  = DATA_W'($urandom);
            step();
            n++;
        end
        wr_valid = 1'b0;
        chk("pre_rst_ptr", m_ptr, 100);
        chk("pre_rst_count", fifo_count, 2);
        do_reset();
        repeat (10) step();

        for (int i = 0; i < 2000; i++) begin
            rd_req   = ($urandom_range(0, 2) == 0);
            rd_addr  = ADDR_W'($urandom_range(0, MEMSZ - 1));
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr  = ADDR_W'($urandom_range(0, MEMSZ - 1));
            wr_data  = DATA_W'($urandom);
            step();
        end
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        repeat (8) step();

        for (int i = 0; i < 64; i++) begin
            a = $urandom_range(0, MEMSZ - 1);
            chk("ram_image", ram[a], gold[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
